// File: rtl/traffic_light_sequencer.sv
// Purpose : Moore FSM sequencing main/side lamps and the pedestrian walk phase.
// Latency : state changes on the expiry edge; lamps decode the state register (one clock later).
// Backpr. : none; timing advances only on Sec_Tick, and the FSM holds while Sec_Tick=0.
//
// Ports:
//   clk          system clock, rising edge
//   Reset_n      asynchronous active-low reset
//   Sec_Tick     one-cycle timing enable from the prescaler
//   WR_Status    pending walk request (already synchronised)
//   Sensor_Sync  side-street vehicle present (already synchronised)
//   Main_Lights  {R,Y,G} main street
//   Side_Lights  {R,Y,G} side street
//   Walk_Lamp    pedestrian walk lamp
//   WR_Reset     one-cycle clear pulse to the walk register
//   State        current state code (debug)
module traffic_light_sequencer #(
  parameter int unsigned T_BASE = 6,
  parameter int unsigned T_EXT  = 3,
  parameter int unsigned T_YEL  = 2
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       Sec_Tick,
  input  logic       WR_Status,
  input  logic       Sensor_Sync,
  output logic [2:0] Main_Lights,
  output logic [2:0] Side_Lights,
  output logic       Walk_Lamp,
  output logic       WR_Reset,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    ST_MG   = 3'd0,
    ST_MY   = 3'd1,
    ST_WALK = 3'd2,
    ST_SG   = 3'd3,
    ST_SY   = 3'd4
  } state_t;

  localparam logic [3:0] LD_BASE = 4'(T_BASE);
  localparam logic [3:0] LD_EXT  = 4'(T_EXT);
  localparam logic [3:0] LD_YEL  = 4'(T_YEL);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ext_done_q, ext_done_d;
  logic       wr_reset_q, wr_reset_d;
  logic       expire;

  // cnt is always loaded with 1..15, so 0 is unreachable; treating it as
  // expired keeps a corrupted counter from freezing the intersection.
  assign expire = Sec_Tick && (cnt_q <= 4'd1);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_MG;
      cnt_q      <= LD_BASE;
      ext_done_q <= 1'b0;
      wr_reset_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ext_done_q <= ext_done_d;
      wr_reset_q <= wr_reset_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ext_done_d = ext_done_q;
    wr_reset_d = 1'b0;
    // Plain countdown; any expiry below overrides it with the next load,
    // so the expiring tick is never applied to the new state.
    cnt_d      = (Sec_Tick && (cnt_q > 4'd1)) ? cnt_q - 4'd1 : cnt_q;

    case (state_q)
      ST_MG: begin
        if (expire) begin
          state_d = ST_MY;
          cnt_d   = LD_YEL;
        end
      end
      ST_MY: begin
        // The walk request is only looked at here.
        if (expire) begin
          if (WR_Status) begin
            state_d = ST_WALK;
            cnt_d   = LD_EXT;
          end else begin
            state_d    = ST_SG;
            cnt_d      = LD_BASE;
            ext_done_d = 1'b0;
          end
        end
      end
      ST_WALK: begin
        if (expire) begin
          state_d    = ST_SG;
          cnt_d      = LD_BASE;
          ext_done_d = 1'b0;
          // Clears the request only after the pedestrian was served, so
          // presses during WALK are absorbed as well.
          wr_reset_d = 1'b1;
        end
      end
      ST_SG: begin
        if (expire) begin
          if (Sensor_Sync && !ext_done_q) begin
            cnt_d      = LD_EXT;
            ext_done_d = 1'b1;
          end else begin
            state_d = ST_SY;
            cnt_d   = LD_YEL;
          end
        end
      end
      ST_SY: begin
        if (expire) begin
          state_d = ST_MG;
          cnt_d   = LD_BASE;
        end
      end
      default: begin
        state_d    = ST_MG;
        cnt_d      = LD_BASE;
        ext_done_d = 1'b0;
      end
    endcase
  end

  // Lamps depend on the state register only.
  always_comb begin
    Main_Lights = LAMP_R;
    Side_Lights = LAMP_R;
    Walk_Lamp   = 1'b0;
    case (state_q)
      ST_MG:   Main_Lights = LAMP_G;
      ST_MY:   Main_Lights = LAMP_Y;
      ST_WALK: Walk_Lamp   = 1'b1;
      ST_SG:   Side_Lights = LAMP_G;
      ST_SY:   Side_Lights = LAMP_Y;
      default: ; // illegal code: all red for the one clock before recovery
    endcase
  end

  assign WR_Reset = wr_reset_q;
  assign State    = state_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
module tb_traffic_light_sequencer;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Sec_Tick = 1'b0;
  logic       WR_Status = 1'b0;
  logic       Sensor_Sync = 1'b0;
  logic [2:0] Main_Lights;
  logic [2:0] Side_Lights;
  logic       Walk_Lamp;
  logic       WR_Reset;
  logic [2:0] State;

  traffic_light_sequencer #(.T_BASE(6), .T_EXT(3), .T_YEL(2)) dut (
    .clk(clk),
    .Reset_n(Reset_n),
    .Sec_Tick(Sec_Tick),
    .WR_Status(WR_Status),
    .Sensor_Sync(Sensor_Sync),
    .Main_Lights(Main_Lights),
    .Side_Lights(Side_Lights),
    .Walk_Lamp(Walk_Lamp),
    .WR_Reset(WR_Reset),
    .State(State)
  );

  always #5 clk = ~clk;

  localparam int MG = 0, MY = 1, WK = 2, SG = 3, SY = 4;

  typedef struct {
    int st;
    int len;
    int wr;   // 1: WR_Reset high in the first clock of the phase only
  } phase_t;

  phase_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic push(input int st, input int len, input int wr);
    phase_t p;
    p.st = st; p.len = len; p.wr = wr;
    exp_q.push_back(p);
  endtask

  task automatic push_idle();
    push(MG, 6, 0); push(MY, 2, 0); push(SG, 6, 0); push(SY, 2, 0);
  endtask

  // Advance n rising edges and land just after the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    logic [10:0] got;
    got = {Main_Lights, Side_Lights, Walk_Lamp, WR_Reset, State};
    checks++;
    if (got !== 11'b001_100_0_0_000) begin
      failures++;
      $display("FAIL reset_outs_%s: got M=%b S=%b W=%b R=%b St=%0d want M=001 S=100 W=0 R=0 St=0",
               tag, got[10:8], got[7:5], got[4], got[3], got[2:0]);
    end
  endtask

  function automatic logic [6:0] lamps_for(input int st);
    case (st)
      MG:      return 7'b001_100_0;
      MY:      return 7'b010_100_0;
      WK:      return 7'b100_100_1;
      SG:      return 7'b100_001_0;
      SY:      return 7'b100_010_0;
      default: return 7'b100_100_0;
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit have = 0;
  int cur_st, cur_len, wr_cnt, wr_first;

  task automatic complete_phase();
    phase_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL phase_extra: got state %0d len %0d, want no more phases", cur_st, cur_len);
      return;
    end
    e = exp_q.pop_front();
    if (cur_st != e.st || cur_len != e.len ||
        wr_cnt != e.wr || (e.wr == 1 && wr_first != 1)) begin
      failures++;
      $display("FAIL phase: got state %0d len %0d wr_cnt %0d wr_first %0d, want state %0d len %0d wr %0d",
               cur_st, cur_len, wr_cnt, wr_first, e.st, e.len, e.wr);
    end
  endtask

  always @(negedge clk) begin
    if (!Reset_n) begin
      have = 0;  // a phase cut by reset is not compared
    end else begin
      if (!have || int'(State) != cur_st) begin
        if (have) complete_phase();
        cur_st   = int'(State);
        cur_len  = 1;
        wr_cnt   = int'(WR_Reset);
        wr_first = int'(WR_Reset);
        have     = 1;
      end else begin
        cur_len++;
        wr_cnt += int'(WR_Reset);
      end
      checks++;
      if (State > 3'd4 || {Main_Lights, Side_Lights, Walk_Lamp} !== lamps_for(int'(State))) begin
        failures++;
        $display("FAIL lamps: state %0d got M=%b S=%b W=%b want %b", State,
                 Main_Lights, Side_Lights, Walk_Lamp, lamps_for(int'(State)));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #12;
    check_reset_outs("por");
    @(posedge clk); #1;
    Reset_n  = 1'b1;          // cycle 0: MG
    Sec_Tick = 1'b1;

    // Idle: two 16-clock periods, no WALK, no WR_Reset
    push_idle(); push_idle();
    cycles(32);

    // Walk request held from MG; the walk register clears after the pulse
    WR_Status = 1'b1;
    push(MG, 6, 0); push(MY, 2, 0); push(WK, 3, 0); push(SG, 6, 1); push(SY, 2, 0);
    push_idle();
    cycles(12);               // cycle 44: first edge after the pulse
    WR_Status = 1'b0;
    cycles(23);               // cycle 67

    // Late request raised in SG: served after the following MY
    push_idle();
    push(MG, 6, 0); push(MY, 2, 0); push(WK, 3, 0); push(SG, 6, 1); push(SY, 2, 0);
    cycles(10);               // cycle 77: SG
    WR_Status = 1'b1;
    cycles(18);               // cycle 95
    WR_Status = 1'b0;
    cycles(7);                // cycle 102

    // Sensor held: SG extended exactly once per visit
    Sensor_Sync = 1'b1;
    push(MG, 6, 0); push(MY, 2, 0); push(SG, 9, 0); push(SY, 2, 0);
    push(MG, 6, 0); push(MY, 2, 0); push(SG, 9, 0); push(SY, 2, 0);
    cycles(38);               // cycle 140

    // Walk plus extension: 22-clock cycle
    WR_Status = 1'b1;
    push(MG, 6, 0); push(MY, 2, 0); push(WK, 3, 0); push(SG, 9, 1); push(SY, 2, 0);
    cycles(12);               // cycle 152
    WR_Status = 1'b0;
    cycles(10);               // cycle 162
    Sensor_Sync = 1'b0;

    // Reset asserted mid-SG
    push(MG, 6, 0); push(MY, 2, 0);
    cycles(10);               // cycle 172: SG
    #2 Reset_n = 1'b0;
    #1 check_reset_outs("mid_sg");
    cycles(2);
    Reset_n = 1'b1;           // new cycle 0

    // Reset during WALK: request survives and is served after the next MY
    WR_Status = 1'b1;
    push(MG, 6, 0); push(MY, 2, 0);
    cycles(9);                // cycle 9: WALK
    #2 Reset_n = 1'b0;
    #1 check_reset_outs("mid_walk");
    cycles(2);
    Reset_n = 1'b1;           // new cycle 0
    push(MG, 6, 0); push(MY, 2, 0); push(WK, 3, 0); push(SG, 6, 1); push(SY, 2, 0);
    cycles(12);
    WR_Status = 1'b0;
    cycles(7);                // cycle 19: MG

    // Tick every 4th clock, then ticks held off for 50 clocks during SG
    push(MG, 24, 0); push(MY, 8, 0); push(SG, 56, 0); push(SY, 2, 0); push(MG, 6, 0);
    for (int k = 0; k < 32; k++) begin
      Sec_Tick = ((k % 4) == 3);
      cycles(1);
    end
    Sec_Tick = 1'b0;
    cycles(50);
    Sec_Tick = 1'b1;

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) cycles(1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d phases pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
